// File: rtl/serial_tx_if.sv
// Handshake and line signals between a word source and the serial transmitter.
// The master side drives the word and load request; the slave side is the
// transmitter, which returns readiness, line state and frame status.
interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] Data;
    logic              Load;
    logic              Ready;
    logic              Tx;
    logic              Busy;
    logic              Done;

    modport master (
        output Data, Load,
        input  Ready, Tx, Busy, Done
    );

    modport slave (
        input  Data, Load,
        output Ready, Tx, Busy, Done
    );
endinterface

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: one start bit (0), DATA_W payload bits sent
// LSB first, one stop bit (1). Every bit is held CLKS_PER_BIT clocks and the
// line idles high. All outputs are registered and decoded from the FSM state.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        Clk,
    input  logic        Resetn,
    serial_tx_if.slave  bus
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // Last cycle of a bit, and the cycle before it (used to raise Done one
    // clock early so the registered pulse lands on the final stop cycle).
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_PRE  = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cyc_q;
    logic [BW-1:0]     bit_q;
    logic [DATA_W-1:0] shreg_q;
    logic              tx_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;

    logic [CW-1:0]     cyc_d;
    logic [BW-1:0]     bit_d;
    logic [DATA_W-1:0] shreg_d;
    logic              cyc_end;

    // Counter increments and the shifted word; only committed by the FSM on
    // the cycles where it decides to advance.
    always_comb begin
        cyc_d   = cyc_q + 1'b1;
        bit_d   = bit_q + 1'b1;
        shreg_d = shreg_q >> 1;
        cyc_end = (cyc_q == CYC_LAST);
    end

    // Frame FSM with registered line and status outputs.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.Load) begin
                        shreg_q <= bus.Data;
                        cyc_q   <= '0;
                        bit_q   <= '0;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (cyc_end) begin
                        cyc_q   <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= shreg_q[0];
                    end else begin
                        cyc_q <= cyc_d;
                    end
                end
                DATA: begin
                    if (cyc_end) begin
                        cyc_q <= '0;
                        if (bit_q == BIT_LAST) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                            // A one-cycle stop bit is also its own last cycle.
                            done_q  <= (CLKS_PER_BIT == 1);
                        end else begin
                            shreg_q <= shreg_d;
                            bit_q   <= bit_d;
                            tx_q    <= shreg_d[0];
                        end
                    end else begin
                        cyc_q <= cyc_d;
                    end
                end
                STOP: begin
                    if (cyc_end) begin
                        cyc_q   <= '0;
                        bit_q   <= '0;
                        shreg_q <= '0;
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cyc_q  <= cyc_d;
                        done_q <= (cyc_q == CYC_PRE);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Tx    = tx_q;
    assign bus.Ready = ready_q;
    assign bus.Busy  = busy_q;
    assign bus.Done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx. Words are pushed to a scoreboard queue when a
// load is driven; a line monitor decodes each frame off Tx, pops the expected
// word and checks every frame cycle (line level, Busy, Ready, Done).
module tb_serial_tx;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int FRAME = (DW + 2) * CPB;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    serial_tx_if #(.DATA_W(8)) bus8 ();
    serial_tx_if #(.DATA_W(4)) bus4 ();

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u8 (.Clk(clk), .Resetn(rstn), .bus(bus8));
    serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) u4 (.Clk(clk), .Resetn(rstn), .bus(bus4));

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          starts[$];
    int          cycle = 0;
    int          frames = 0;
    int          done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cycle++;

    // Line monitor / receiver model for the 8-bit instance.
    logic       mon_act = 1'b0;
    int         n = 0;
    logic [7:0] w = '0;
    always @(negedge clk) begin
        int   b;
        logic expbit;
        if (bus8.Done === 1'b1) done_cnt++;
        if (!rstn) mon_act = 1'b0;
        if (rstn && !mon_act && bus8.Tx === 1'b0) begin
            mon_act = 1'b1;
            n = 0;
            starts.push_back(cycle);
            check("frame_expected", exp_q.size() != 0, 1);
            w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        end
        if (mon_act) begin
            if (n < FRAME) begin
                b = n / CPB;
                expbit = (b == 0) ? 1'b0 : (b == DW + 1) ? 1'b1 : w[b-1];
                check("tx_bit", bus8.Tx, expbit);
                check("busy_frame", bus8.Busy, 1);
                check("ready_frame", bus8.Ready, 0);
                check("done_frame", bus8.Done, (n == FRAME - 1));
                n++;
            end else begin
                check("tx_after", bus8.Tx, 1);
                check("ready_after", bus8.Ready, 1);
                check("busy_after", bus8.Busy, 0);
                check("done_after", bus8.Done, 0);
                frames++;
                mon_act = 1'b0;
            end
        end else begin
            check("tx_idle", bus8.Tx, 1);
            check("ready_idle", bus8.Ready, 1);
            check("busy_idle", bus8.Busy, 0);
        end
    end

    // Called just after a rising edge; the load is accepted at the next edge.
    task automatic send(input logic [7:0] d);
        bus8.Load = 1'b1;
        bus8.Data = d;
        exp_q.push_back(d);
        @(posedge clk); #1;
        bus8.Load = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int k = 0;
        while (frames < target && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        check("frame_timeout", frames >= target, 1);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (bus8.Ready !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("ready_timeout", bus8.Ready, 1);
    endtask

    initial begin
        logic [5:0] t5_exp;
        int         f0;
        int         d0;
        bus8.Load = 1'b0; bus8.Data = '0;
        bus4.Load = 1'b0; bus4.Data = '0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", bus8.Tx, 1);
        check("rst_ready", bus8.Ready, 1);
        check("rst_busy", bus8.Busy, 0);
        check("rst_done", bus8.Done, 0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: single A5 frame, first start cycle right after the accept edge
        f0 = frames;
        send(8'hA5);
        @(negedge clk);
        check("t1_first_start", bus8.Tx, 0);
        wait_frames(f0 + 1);

        // 2: Load held high, 00 then FF, one idle cycle between frames
        @(posedge clk); #1;
        f0 = frames;
        bus8.Load = 1'b1; bus8.Data = 8'h00; exp_q.push_back(8'h00);
        @(posedge clk); #1;
        bus8.Data = 8'hFF; exp_q.push_back(8'hFF);
        repeat (FRAME + 1) @(posedge clk);
        #1;
        bus8.Load = 1'b0;
        wait_frames(f0 + 2);
        check("t2_gap", starts[starts.size()-1] - starts[starts.size()-2], FRAME + 1);

        // 3: Data change and second Load during DATA are ignored
        @(posedge clk); #1;
        f0 = frames;
        send(8'h3C);
        repeat (2 * CPB + 3) @(posedge clk);
        #1;
        bus8.Data = 8'hC3; bus8.Load = 1'b1;
        @(posedge clk); #1;
        bus8.Load = 1'b0;
        wait_frames(f0 + 1);
        repeat (FRAME + 10) @(posedge clk);
        #1;
        check("t3_single_frame", frames, f0 + 1);

        // 4: asynchronous reset in data bit 3, then a clean frame
        f0 = frames;
        send(8'h52);
        repeat (17) @(posedge clk);
        #2;
        check("t4_pre_bit3", bus8.Tx, 0);
        rstn = 1'b0;
        #1;
        check("t4_rst_tx", bus8.Tx, 1);
        check("t4_rst_busy", bus8.Busy, 0);
        check("t4_rst_ready", bus8.Ready, 1);
        check("t4_rst_done", bus8.Done, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        send(8'hE7);
        wait_frames(f0 + 1);

        // 5: DATA_W=4, CLKS_PER_BIT=1, word 1001
        t5_exp = 6'b110010;  // cycle i expects bit i: 0,1,0,0,1,1
        @(posedge clk); #1;
        bus4.Load = 1'b1; bus4.Data = 4'b1001;
        @(posedge clk); #1;
        bus4.Load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t5_tx", bus4.Tx, t5_exp[i]);
            check("t5_busy", bus4.Busy, 1);
            check("t5_done", bus4.Done, (i == 5));
        end
        @(negedge clk);
        check("t5_ready_after", bus4.Ready, 1);
        check("t5_tx_after", bus4.Tx, 1);

        // 6: 16 random words through the receiver model
        @(posedge clk); #1;
        f0 = frames;
        d0 = done_cnt;
        for (int i = 0; i < 16; i++) begin
            wait_ready();
            send(8'($urandom));
        end
        wait_frames(f0 + 16);
        @(posedge clk); #1;
        check("t6_done_count", done_cnt - d0, 16);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-to-serial transmitter. It frames a DATA_W-bit word with one start bit and one stop bit, then shifts it out LSB-first on a single line. The line idles high. This block is the sending end of the team's serial link lab: it drives the line that a latch/flip-flop based serial receiver samples. Its register and shift stages are built on the team's edge-triggered flip-flop chain.

Parameters:
DATA_W, 8, payload bits per frame; legal range 1..16.
CLKS_PER_BIT, 4, Clk cycles each bit is held on Tx; legal range 1..1024.

Ports:
Clk  input  1  system clock; all state changes on rising edge.
Resetn  input  1  asynchronous, active-low reset.
Data  input  DATA_W  word to transmit; sampled only on an accepted load.
Load  input  1  request to send Data.
Ready  output  1  high when a Load will be accepted this cycle.
Tx  output  1  serial line; idle high.
Busy  output  1  high while a frame is in progress.
Done  output  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset (Resetn=0, asynchronous, any time including mid-frame):
  - outputs: Tx=1, Ready=1, Busy=0, Done=0.
  - state = IDLE; bit counter, cycle counter and shift register all cleared.
  - A frame in progress is abandoned. No partial stop bit is sent; Tx goes high immediately.
- Counters:
  - cycle counter width = $clog2(CLKS_PER_BIT), minimum 1 bit.
  - bit index width = $clog2(DATA_W), minimum 1 bit.
  - Both are unsigned and wrap only under explicit reload. Never rely on natural overflow.
- FSM states: IDLE, START, DATA, STOP. Tx, Ready and Busy are registered; they are decoded from state, not from inputs.
- IDLE:
  - Tx=1, Ready=1, Busy=0.
  - Load=1 at a rising edge: capture Data into the shift register, clear the cycle counter, go to START.
  - Load=0: stay in IDLE.
- START:
  - Tx=0, Ready=0, Busy=1.
  - Held for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - Tx = shift register bit 0 (LSB first).
  - Each bit is held CLKS_PER_BIT cycles. At the end of each bit, shift right one place and increment the bit index.
  - After bit DATA_W-1, go to STOP.
- STOP:
  - Tx=1, held CLKS_PER_BIT cycles.
  - Done=1 during the final cycle of STOP only, then go to IDLE.
- Latency and frame length:
  - First start-bit cycle on Tx is the cycle after the accepting edge.
  - Full frame = (DATA_W+2)*CLKS_PER_BIT cycles.
  - Ready rises the cycle after Done.
- Back-to-back frames: if Load is held high, the next word is accepted on the first IDLE cycle. Consecutive frames are therefore separated by exactly one idle-high cycle.
- Load while Ready=0: ignored. Data changes during a frame have no effect; the captured word is transmitted unchanged.
- Load coincident with reset deassertion: no frame starts until the first rising edge that sees Resetn=1 and Load=1.
- CLKS_PER_BIT=1: each state lasts one cycle; the counter logic must still produce exact 1-cycle bits.
- X/Z on Load in IDLE is a bench error. The DUT is not required to tolerate it.

Test Plan:
1. Reset, then Load=1 for one cycle with Data=8'hA5, CLKS_PER_BIT=4 -> Tx sequence 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles. Busy high for 40 cycles. Done pulses on cycle 40. Ready returns high on cycle 41.
2. Load held high with Data=8'h00, then 8'hFF -> two frames separated by exactly one Tx=1 idle cycle. Second frame has data bits all 1.
3. Pulse Load with 8'h3C, then change Data to 8'hC3 and pulse Load during DATA -> frame carries 8'h3C. The second Load is ignored and no second frame is sent.
4. Assert Resetn=0 mid-DATA (bit 3) -> Tx=1, Busy=0, Ready=1 within the same cycle, without waiting for a clock edge. A fresh Load afterwards produces a clean full frame.
5. CLKS_PER_BIT=1, DATA_W=4, Data=4'b1001 -> Tx 0,1,0,0,1,1 on consecutive cycles. Done coincides with the stop-bit cycle.
6. Loopback: connect Tx to the team's serial receiver lab block with matching parameters and send 16 random words -> every received word matches the sent word, and Done count equals 16.
